// File: rtl/minmax_scan_engine.sv
// Scans n words of a synchronous-read memory and reports the max or min value, its index and address.
// Defining MINMAX_SUM_EN adds a sum output holding the total of the scanned words.
module minmax_scan_engine #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic                     mclk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     mode,
  input  logic                     sgn,
  input  logic [CNT_W-1:0]         n,
  input  logic [ADDR_W-1:0]        startaddr,
  output logic                     mem_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_W-1:0]        result,
  output logic [CNT_W-1:0]         result_idx,
  output logic [ADDR_W-1:0]        result_addr,
`ifdef MINMAX_SUM_EN
  output logic [DATA_W+CNT_W-1:0]  sum,
`endif
  output logic                     empty
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_t;

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [RD_LAT-1:0] VLD_TAIL = RD_LAT'(1) << (RD_LAT - 1);

  state_t            state, state_nxt;
  logic              mode_q, sgn_q;
  logic [CNT_W-1:0]  n_q, cnt;
  logic [ADDR_W-1:0] base;
  logic [RD_LAT-1:0] vld_sr;
  logic [CNT_W-1:0]  idx_sr [RD_LAT];
  logic              accept, last_issue, drain_last, rd_vld, gt, lt, better;
  logic [CNT_W-1:0]  rd_idx;

  assign accept     = (state == S_IDLE) && start;
  assign last_issue = (cnt == n_q - CNT_ONE);
  // Safe to finish once only the word being consumed this cycle is still in flight.
  assign drain_last = (vld_sr & ~VLD_TAIL) == '0;
  assign rd_vld     = vld_sr[RD_LAT-1];
  assign rd_idx     = idx_sr[RD_LAT-1];

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = (n == '0) ? S_FIN : S_ISSUE;
      S_ISSUE: begin
        busy = 1'b1;
        if (last_issue) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_last) state_nxt = S_FIN;
      end
      S_FIN: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    gt = 1'b0;
    lt = 1'b0;
    if (sgn_q) begin
      gt = $signed(mem_rdata) > $signed(result);
      lt = $signed(mem_rdata) < $signed(result);
    end else begin
      gt = mem_rdata > result;
      lt = mem_rdata < result;
    end
    // Index 0 always loads; later words need a strict improvement so ties keep the earliest.
    better = (rd_idx == '0) || (mode_q ? lt : gt);
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      mode_q      <= 1'b0;
      sgn_q       <= 1'b0;
      n_q         <= '0;
      base        <= '0;
      cnt         <= '0;
      mem_en      <= 1'b0;
      mem_addr    <= '0;
      vld_sr      <= '0;
      for (int k = 0; k < RD_LAT; k++) idx_sr[k] <= '0;
      result      <= '0;
      result_idx  <= '0;
      result_addr <= '0;
      empty       <= 1'b0;
    end else begin
      state     <= state_nxt;
      vld_sr[0] <= mem_en;
      idx_sr[0] <= cnt;
      for (int k = 1; k < RD_LAT; k++) begin
        vld_sr[k] <= vld_sr[k-1];
        idx_sr[k] <= idx_sr[k-1];
      end
      if (accept) begin
        mode_q      <= mode;
        sgn_q       <= sgn;
        n_q         <= n;
        base        <= startaddr;
        cnt         <= '0;
        mem_en      <= (n != '0);
        if (n != '0) mem_addr <= startaddr;
        result      <= '0;
        result_idx  <= '0;
        result_addr <= (n == '0) ? startaddr : '0;
        empty       <= (n == '0);
      end else if (state == S_ISSUE) begin
        if (last_issue) begin
          mem_en <= 1'b0;
        end else begin
          mem_addr <= mem_addr + ADDR_W'(1);
          cnt      <= cnt + CNT_ONE;
        end
      end
      if (rd_vld && better) begin
        result      <= mem_rdata;
        result_idx  <= rd_idx;
        result_addr <= base + ADDR_W'(rd_idx);
      end
    end
  end

`ifdef MINMAX_SUM_EN
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      sum <= '0;
    end else if (accept) begin
      sum <= '0;
    end else if (rd_vld) begin
      sum <= sum + {{CNT_W{sgn_q & mem_rdata[DATA_W-1]}}, mem_rdata};
    end
  end
`endif

endmodule

// File: tb/tb_minmax_scan_engine.sv
// Bench for minmax_scan_engine: two instances (read latency 1 and 3) run the same directed scans
// against a scan-level model plus literal expectations from hand-worked cases.
`timescale 1ns/1ps
module tb_minmax_scan_engine;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic        mclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0, mode = 1'b0, sgn = 1'b0;
  logic [7:0]  n = 8'd0;
  logic [15:0] startaddr = 16'd0;

  logic        mem_en_w [2];
  logic [15:0] mem_addr_w [2];
  logic [15:0] rdata_w [2];
  logic        busy_w [2], done_w [2], empty_w [2];
  logic [15:0] result_w [2], raddr_w [2];
  logic [7:0]  idx_w [2];
`ifdef MINMAX_SUM_EN
  logic [23:0] sum_w [2];
`endif

  logic [15:0] mem [65536];
  logic [15:0] rp [2][4];
  int          n_chk = 0, n_fail = 0;

  // model state
  int          lat [2] = '{LAT0, LAT1};
  bit          act [2];
  int          k [2], dc [2], dcyc [2];
  logic [7:0]  m_n [2];
  logic [15:0] m_sa [2];
  logic [15:0] ex_res [2], ex_addr [2], last_ma [2];
  logic [7:0]  ex_idx [2];
  logic        ex_empty [2];
  logic [23:0] ex_sum [2];
  logic        cmp_en;
  logic [15:0] cmp_addr;

  always #5 mclk = ~mclk;

  minmax_scan_engine #(.DATA_W(16), .ADDR_W(16), .CNT_W(8), .RD_LAT(LAT0)) dut_l1 (
    .mclk(mclk), .reset_n(reset_n), .start(start), .mode(mode), .sgn(sgn), .n(n),
    .startaddr(startaddr), .mem_en(mem_en_w[0]), .mem_addr(mem_addr_w[0]),
    .mem_rdata(rdata_w[0]), .busy(busy_w[0]), .done(done_w[0]), .result(result_w[0]),
    .result_idx(idx_w[0]), .result_addr(raddr_w[0]),
`ifdef MINMAX_SUM_EN
    .sum(sum_w[0]),
`endif
    .empty(empty_w[0]));

  minmax_scan_engine #(.DATA_W(16), .ADDR_W(16), .CNT_W(8), .RD_LAT(LAT1)) dut_l3 (
    .mclk(mclk), .reset_n(reset_n), .start(start), .mode(mode), .sgn(sgn), .n(n),
    .startaddr(startaddr), .mem_en(mem_en_w[1]), .mem_addr(mem_addr_w[1]),
    .mem_rdata(rdata_w[1]), .busy(busy_w[1]), .done(done_w[1]), .result(result_w[1]),
    .result_idx(idx_w[1]), .result_addr(raddr_w[1]),
`ifdef MINMAX_SUM_EN
    .sum(sum_w[1]),
`endif
    .empty(empty_w[1]));

  // Memory with a read pipeline per instance; invalid slots return a marker value.
  always @(posedge mclk) begin
    for (int d = 0; d < 2; d++) begin
      for (int s = 3; s > 0; s--) rp[d][s] <= rp[d][s-1];
      rp[d][0] <= mem_en_w[d] ? mem[mem_addr_w[d]] : 16'hDEAD;
    end
  end
  assign rdata_w[0] = rp[0][LAT0-1];
  assign rdata_w[1] = rp[1][LAT1-1];

  task automatic chk(input string nm, input int d, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL lat%0d %s: got 0x%0h, expected 0x%0h", lat[d], nm, a, e);
    end
  endtask

  function automatic bit better(input logic [15:0] v, input logic [15:0] r,
                                input logic md, input logic sg);
    int a, b;
    if (sg) begin
      a = $signed(v);
      b = $signed(r);
    end else begin
      a = int'(v);
      b = int'(r);
    end
    return md ? (a < b) : (a > b);
  endfunction

  // Scan-level model: on acceptance compute the whole answer from memory contents.
  always @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int d = 0; d < 2; d++) begin
        act[d] = 1'b0; k[d] = 0; dc[d] = 0; m_n[d] = 8'd0; m_sa[d] = 16'd0;
        ex_res[d] = 16'd0; ex_idx[d] = 8'd0; ex_addr[d] = 16'd0; ex_empty[d] = 1'b0;
        ex_sum[d] = 24'd0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (act[d]) begin
          if (k[d] == dc[d]) act[d] = 1'b0;
          else k[d]++;
        end else if (start) begin
          logic [15:0] a, v;
          act[d] = 1'b1; k[d] = 1; m_n[d] = n; m_sa[d] = startaddr;
          dc[d] = (n == 8'd0) ? 1 : int'(n) + lat[d] + 1;
          ex_res[d] = 16'd0; ex_idx[d] = 8'd0; ex_sum[d] = 24'd0;
          for (int i = 0; i < int'(n); i++) begin
            a = startaddr + 16'(i);
            v = mem[a];
            if (i == 0 || better(v, ex_res[d], mode, sgn)) begin
              ex_res[d] = v;
              ex_idx[d] = 8'(i);
            end
            ex_sum[d] = ex_sum[d] + (sgn ? {{8{v[15]}}, v} : {8'd0, v});
          end
          ex_addr[d]  = startaddr + 16'(ex_idx[d]);
          ex_empty[d] = (n == 8'd0);
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge mclk) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset_n) begin
        last_ma[d] = 16'd0;
        chk("rst done", d, 32'(done_w[d]), 32'd0);
        chk("rst mem_en", d, 32'(mem_en_w[d]), 32'd0);
        chk("rst busy", d, 32'(busy_w[d]), 32'd0);
        chk("rst mem_addr", d, 32'(mem_addr_w[d]), 32'd0);
        chk("rst result", d, 32'(result_w[d]), 32'd0);
      end else if (act[d]) begin
        if (k[d] == 1) dcyc[d] = -1;
        cmp_en = (k[d] >= 1) && (k[d] <= int'(m_n[d]));
        cmp_addr = cmp_en ? m_sa[d] + 16'(k[d] - 1) : last_ma[d];
        chk("mem_en", d, 32'(mem_en_w[d]), 32'(cmp_en));
        chk("mem_addr", d, 32'(mem_addr_w[d]), 32'(cmp_addr));
        if (cmp_en) last_ma[d] = cmp_addr;
        chk("done", d, 32'(done_w[d]), 32'(k[d] == dc[d]));
        if (done_w[d] && dcyc[d] < 0) dcyc[d] = k[d];
        if (k[d] < dc[d]) chk("busy", d, 32'(busy_w[d]), 32'd1);
        if (k[d] == dc[d]) begin
          chk("final result", d, 32'(result_w[d]), 32'(ex_res[d]));
          chk("final idx", d, 32'(idx_w[d]), 32'(ex_idx[d]));
          chk("final addr", d, 32'(raddr_w[d]), 32'(ex_addr[d]));
          chk("final empty", d, 32'(empty_w[d]), 32'(ex_empty[d]));
`ifdef MINMAX_SUM_EN
          chk("final sum", d, 32'(sum_w[d]), 32'(ex_sum[d]));
`endif
        end else if (k[d] == 1) begin
          chk("clear result", d, 32'(result_w[d]), 32'd0);
          chk("clear idx", d, 32'(idx_w[d]), 32'd0);
          chk("clear addr", d, 32'(raddr_w[d]), 32'd0);
          chk("clear empty", d, 32'(empty_w[d]), 32'd0);
        end
      end else begin
        chk("idle done", d, 32'(done_w[d]), 32'd0);
        chk("idle mem_en", d, 32'(mem_en_w[d]), 32'd0);
        chk("idle busy", d, 32'(busy_w[d]), 32'd0);
        chk("idle mem_addr", d, 32'(mem_addr_w[d]), 32'(last_ma[d]));
        chk("hold result", d, 32'(result_w[d]), 32'(ex_res[d]));
        chk("hold idx", d, 32'(idx_w[d]), 32'(ex_idx[d]));
        chk("hold addr", d, 32'(raddr_w[d]), 32'(ex_addr[d]));
        chk("hold empty", d, 32'(empty_w[d]), 32'(ex_empty[d]));
`ifdef MINMAX_SUM_EN
        chk("hold sum", d, 32'(sum_w[d]), 32'(ex_sum[d]));
`endif
      end
    end
  end

  task automatic go(input logic md, input logic sg, input logic [7:0] nn,
                    input logic [15:0] sa, input int hold);
    @(negedge mclk);
    mode = md; sgn = sg; n = nn; startaddr = sa; start = 1'b1;
    repeat (hold) @(negedge mclk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int c = 0;
    while ((act[0] || act[1]) && c < 300) begin
      @(negedge mclk);
      c++;
    end
    chk({nm, " completes"}, 0, 32'(act[0] || act[1]), 32'd0);
  endtask

  task automatic lit(input string nm, input logic [15:0] r, input logic [7:0] i,
                     input logic [15:0] a, input logic e, input int c1, input int c3);
    for (int d = 0; d < 2; d++) begin
      chk({nm, " result"}, d, 32'(result_w[d]), 32'(r));
      chk({nm, " idx"}, d, 32'(idx_w[d]), 32'(i));
      chk({nm, " addr"}, d, 32'(raddr_w[d]), 32'(a));
      chk({nm, " empty"}, d, 32'(empty_w[d]), 32'(e));
      chk({nm, " done cycle"}, d, 32'(dcyc[d]), 32'(d == 0 ? c1 : c3));
    end
  endtask

  task automatic load5(input logic [15:0] v2);
    mem[16'h10] = 16'd3; mem[16'h11] = 16'd9; mem[16'h12] = v2;
    mem[16'h13] = 16'd9; mem[16'h14] = 16'd5;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'd0;
    reset_n = 1'b0;
    repeat (3) @(negedge mclk);
    for (int d = 0; d < 2; d++) begin
      chk("reset result", d, 32'(result_w[d]), 32'd0);
      chk("reset busy", d, 32'(busy_w[d]), 32'd0);
      chk("reset mem_addr", d, 32'(mem_addr_w[d]), 32'd0);
    end
    reset_n = 1'b1;

    load5(16'd2);
    go(1'b0, 1'b0, 8'd5, 16'h0010, 1);
    wait_idle("umax");
    lit("umax", 16'd9, 8'd1, 16'h0011, 1'b0, 7, 9);
`ifdef MINMAX_SUM_EN
    for (int d = 0; d < 2; d++) chk("umax sum", d, 32'(sum_w[d]), 32'd28);
`endif

    load5(16'hFFFE);
    go(1'b1, 1'b1, 8'd5, 16'h0010, 1);
    wait_idle("smin");
    lit("smin", 16'hFFFE, 8'd2, 16'h0012, 1'b0, 7, 9);
`ifdef MINMAX_SUM_EN
    for (int d = 0; d < 2; d++) chk("smin sum", d, 32'(sum_w[d]), 32'h000018);
`endif

    go(1'b1, 1'b0, 8'd5, 16'h0010, 1);
    wait_idle("umin");
    lit("umin", 16'd3, 8'd0, 16'h0010, 1'b0, 7, 9);
`ifdef MINMAX_SUM_EN
    for (int d = 0; d < 2; d++) chk("umin sum", d, 32'(sum_w[d]), 32'h010018);
`endif

    mem[16'hFFFE] = 16'd1; mem[16'hFFFF] = 16'd7; mem[16'h0000] = 16'd4; mem[16'h0001] = 16'd0;
    go(1'b0, 1'b0, 8'd4, 16'hFFFE, 1);
    wait_idle("wrap");
    lit("wrap", 16'd7, 8'd1, 16'hFFFF, 1'b0, 6, 8);

    // start held into the done cycle of an empty scan must not retrigger
    go(1'b0, 1'b0, 8'd0, 16'h0042, 2);
    wait_idle("n0");
    lit("n0", 16'd0, 8'd0, 16'h0042, 1'b1, 1, 1);

    mem[16'h0200] = 16'h1234;
    go(1'b0, 1'b0, 8'd1, 16'h0200, 1);
    wait_idle("n1");
    lit("n1", 16'h1234, 8'd0, 16'h0200, 1'b0, 3, 5);

    for (int i = 0; i < 8; i++) mem[16'h0300 + 16'(i)] = 16'(i + 1);
    go(1'b0, 1'b0, 8'd8, 16'h0300, 1);
    repeat (3) @(negedge mclk);
    mode = 1'b1; n = 8'd2; startaddr = 16'h0010; start = 1'b1;
    @(negedge mclk);
    start = 1'b0;
    wait_idle("asc");
    lit("asc", 16'd8, 8'd7, 16'h0307, 1'b0, 10, 12);

    load5(16'd2);
    go(1'b0, 1'b0, 8'd5, 16'h0010, 1);
    repeat (2) @(negedge mclk);
    #1 reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("abort mem_en", d, 32'(mem_en_w[d]), 32'd0);
      chk("abort mem_addr", d, 32'(mem_addr_w[d]), 32'd0);
      chk("abort busy", d, 32'(busy_w[d]), 32'd0);
      chk("abort done", d, 32'(done_w[d]), 32'd0);
      chk("abort result", d, 32'(result_w[d]), 32'd0);
    end
    repeat (2) @(negedge mclk);
    reset_n = 1'b1;
    go(1'b0, 1'b0, 8'd5, 16'h0010, 1);
    wait_idle("post reset");
    lit("post reset", 16'd9, 8'd1, 16'h0011, 1'b0, 7, 9);

    repeat (3) @(negedge mclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
